// File: rtl/ads5296a_pkg.sv
// Shared widths, FSM state encodings and the frame-rotation matcher for the
// ADS5296A link-training sequencer.
package ads5296a_pkg;

  localparam int unsigned TAP_W    = 5;
  localparam int unsigned FRAME_W  = 10;
  localparam int unsigned NUM_TAPS = 32;
  localparam int unsigned LEN_W    = 6;
  localparam int unsigned SLIP_W   = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ERR_W    = 16;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE         = 4'd0;
  localparam state_t S_LOAD         = 4'd1;
  localparam state_t S_SETTLE       = 4'd2;
  localparam state_t S_CHECK        = 4'd3;
  localparam state_t S_NEXT         = 4'd4;
  localparam state_t S_EVAL         = 4'd5;
  localparam state_t S_APPLY        = 4'd6;
  localparam state_t S_APPLY_SETTLE = 4'd7;
  localparam state_t S_SLIP_CHECK   = 4'd8;
  localparam state_t S_SLIP         = 4'd9;
  localparam state_t S_SLIP_WAIT    = 4'd10;
  localparam state_t S_DONE         = 4'd11;
  localparam state_t S_FAIL         = 4'd12;

  // True when frame equals any of the FRAME_W circular rotations of pattern.
  function automatic logic is_frame_rotation(input logic [FRAME_W-1:0] frame,
                                             input logic [FRAME_W-1:0] pattern);
    logic [2*FRAME_W-1:0] dbl;
    logic                 hit;
    dbl = {pattern, pattern};
    hit = 1'b0;
    for (int unsigned r = 0; r < FRAME_W; r++) begin
      if (frame == dbl[r +: FRAME_W]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ads5296a_eye_tracker.sv
// Tracks the current run of good taps during the sweep and keeps the widest
// one seen; ties keep the earlier run.
module ads5296a_eye_tracker
  import ads5296a_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_update,
  input  logic [TAP_W-1:0] i_tap,
  input  logic             i_good,
  output logic [TAP_W-1:0] o_best_start,
  output logic [LEN_W-1:0] o_best_len
);

  logic [TAP_W-1:0] r_run_start;
  logic [LEN_W-1:0] r_run_len;
  logic [TAP_W-1:0] r_best_start;
  logic [LEN_W-1:0] r_best_len;
  logic [TAP_W-1:0] w_run_start;
  logic [LEN_W-1:0] w_run_len;
  logic             w_close;

  // Run as it stands after this tap is folded in.
  always_comb begin
    w_run_start = r_run_start;
    w_run_len   = r_run_len;
    if (i_good) begin
      if (r_run_len == '0) w_run_start = i_tap;
      w_run_len = r_run_len + LEN_W'(1);
    end
  end

  assign w_close = !i_good || (i_tap == TAP_W'(NUM_TAPS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (i_clear) begin
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (i_update) begin
      if (w_close) begin
        r_run_len <= '0;
        if (w_run_len > r_best_len) begin
          r_best_len   <= w_run_len;
          r_best_start <= w_run_start;
        end
      end else begin
        r_run_start <= w_run_start;
        r_run_len   <= w_run_len;
      end
    end
  end

  assign o_best_start = r_best_start;
  assign o_best_len   = r_best_len;

endmodule

// File: rtl/ads5296a_align_ctrl.sv
// ADS5296A LVDS link training: IDELAY eye sweep, centring, then bitslip alignment.
// Optional lock monitor in DONE enabled by ADS5296A_ALIGN_MONITOR_EN.
module ads5296a_align_ctrl
  import ads5296a_pkg::*;
#(
  parameter logic [FRAME_W-1:0] FRAME_PATTERN = 10'h3E0,
  parameter int unsigned        SETTLE_CYCLES = 8,
  parameter int unsigned        CHECK_SAMPLES = 16,
  parameter int unsigned        MIN_EYE       = 4,
  parameter int unsigned        MAX_SLIPS     = 10
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic [TAP_W-1:0]   idelay_val_o,
  output logic               idelay_ld_o,
  output logic               bitslip_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [TAP_W-1:0]   tap_o,
  output logic [LEN_W-1:0]   eye_width_o
`ifdef ADS5296A_ALIGN_MONITOR_EN
  ,
  output logic [ERR_W-1:0]   err_cnt_o,
  output logic               lost_lock_o
`endif
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CHK_W = $clog2(CHECK_SAMPLES + 1);

  state_t           r_state, w_state_nx;
  logic [TAP_W-1:0] r_tap, w_tap_nx;
  logic [SET_W-1:0] r_settle, w_settle_nx;
  logic [CHK_W-1:0] r_chk, w_chk_nx;
  logic             r_good, w_good_nx;
  logic [SLIP_W-1:0] r_slips, w_slips_nx;
  logic [FRAME_W-1:0] r_prev_frame;
  logic [TAP_W-1:0] r_idelay_val, w_idelay_val_nx;
  logic             r_ld, w_ld_nx;
  logic             r_bitslip, w_bitslip_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             r_error, w_error_nx;
  logic [TAP_W-1:0] r_tap_sel, w_tap_sel_nx;
  logic [LEN_W-1:0] r_eye_width, w_eye_width_nx;

  logic             w_start;
  logic             w_frame_ok;
  logic             w_frame_eq;
  logic [TAP_W-1:0] w_best_start;
  logic [LEN_W-1:0] w_best_len;
  logic [TAP_W-1:0] w_centre;

`ifdef ADS5296A_ALIGN_MONITOR_EN
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nx;
  logic [2:0]       r_miss, w_miss_nx;
  logic             r_lost, w_lost_nx;
`endif

  assign w_start    = start_i && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_FAIL));
  assign w_frame_ok = is_frame_rotation(frame_i, FRAME_PATTERN) && (frame_i == r_prev_frame);
  assign w_frame_eq = (frame_i == FRAME_PATTERN);
  assign w_centre   = TAP_W'(LEN_W'(w_best_start) + ((w_best_len - LEN_W'(1)) >> 1));

  ads5296a_eye_tracker u_eye (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_clear      (w_start),
    .i_update     (r_state == S_NEXT),
    .i_tap        (r_tap),
    .i_good       (r_good),
    .o_best_start (w_best_start),
    .o_best_len   (w_best_len)
  );

  // Next-state and next-output logic; strobes are high exactly while in LOAD/APPLY/SLIP.
  always_comb begin
    w_state_nx      = r_state;
    w_tap_nx        = r_tap;
    w_settle_nx     = r_settle;
    w_chk_nx        = r_chk;
    w_good_nx       = r_good;
    w_slips_nx      = r_slips;
    w_idelay_val_nx = r_idelay_val;
    w_tap_sel_nx    = r_tap_sel;
    w_eye_width_nx  = r_eye_width;

    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (w_start) begin
          w_state_nx      = S_LOAD;
          w_tap_nx        = '0;
          w_slips_nx      = '0;
          w_idelay_val_nx = '0;
        end
      end
      S_LOAD: begin
        w_state_nx  = S_SETTLE;
        w_settle_nx = '0;
      end
      S_SETTLE, S_APPLY_SETTLE, S_SLIP_WAIT: begin
        if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
          w_state_nx = (r_state == S_SETTLE) ? S_CHECK : S_SLIP_CHECK;
          w_chk_nx   = '0;
        end else begin
          w_settle_nx = r_settle + SET_W'(1);
        end
      end
      S_CHECK: begin
        if (!w_frame_ok) begin
          w_good_nx  = 1'b0;
          w_state_nx = S_NEXT;
        end else if (r_chk == CHK_W'(CHECK_SAMPLES - 1)) begin
          w_good_nx  = 1'b1;
          w_state_nx = S_NEXT;
        end else begin
          w_chk_nx = r_chk + CHK_W'(1);
        end
      end
      S_NEXT: begin
        if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
          w_state_nx = S_EVAL;
        end else begin
          w_tap_nx        = r_tap + TAP_W'(1);
          w_idelay_val_nx = r_tap + TAP_W'(1);
          w_state_nx      = S_LOAD;
        end
      end
      S_EVAL: begin
        w_eye_width_nx = w_best_len;
        if (w_best_len < LEN_W'(MIN_EYE)) begin
          w_state_nx = S_FAIL;
        end else begin
          w_tap_sel_nx    = w_centre;
          w_idelay_val_nx = w_centre;
          w_state_nx      = S_APPLY;
        end
      end
      S_APPLY: begin
        w_state_nx  = S_APPLY_SETTLE;
        w_settle_nx = '0;
      end
      S_SLIP_CHECK: begin
        if (!w_frame_eq) begin
          w_state_nx = (r_slips == SLIP_W'(MAX_SLIPS)) ? S_FAIL : S_SLIP;
        end else if (r_chk == CHK_W'(CHECK_SAMPLES - 1)) begin
          w_state_nx = S_DONE;
        end else begin
          w_chk_nx = r_chk + CHK_W'(1);
        end
      end
      S_SLIP: begin
        w_slips_nx  = r_slips + SLIP_W'(1);
        w_settle_nx = '0;
        w_state_nx  = S_SLIP_WAIT;
      end
      default: w_state_nx = S_IDLE;
    endcase

`ifdef ADS5296A_ALIGN_MONITOR_EN
    w_err_cnt_nx = r_err_cnt;
    w_miss_nx    = r_miss;
    w_lost_nx    = r_lost;
    if (w_start) begin
      w_err_cnt_nx = '0;
      w_miss_nx    = '0;
      w_lost_nx    = 1'b0;
    end else if (r_state == S_DONE) begin
      if (!w_frame_eq) begin
        if (r_err_cnt != '1) w_err_cnt_nx = r_err_cnt + ERR_W'(1);
        if (r_miss != 3'd4) w_miss_nx = r_miss + 3'd1;
        if (w_miss_nx == 3'd4) w_lost_nx = 1'b1;
      end else begin
        w_miss_nx = '0;
      end
    end
`endif

    w_ld_nx      = (w_state_nx == S_LOAD) || (w_state_nx == S_APPLY);
    w_bitslip_nx = (w_state_nx == S_SLIP);
    w_busy_nx    = !((w_state_nx == S_IDLE) || (w_state_nx == S_DONE) || (w_state_nx == S_FAIL));
    w_error_nx   = (w_state_nx == S_FAIL);
`ifdef ADS5296A_ALIGN_MONITOR_EN
    w_done_nx    = (w_state_nx == S_DONE) && !w_lost_nx;
`else
    w_done_nx    = (w_state_nx == S_DONE);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_settle     <= '0;
      r_chk        <= '0;
      r_good       <= 1'b0;
      r_slips      <= '0;
      r_prev_frame <= '0;
      r_idelay_val <= '0;
      r_ld         <= 1'b0;
      r_bitslip    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_tap_sel    <= '0;
      r_eye_width  <= '0;
`ifdef ADS5296A_ALIGN_MONITOR_EN
      r_err_cnt    <= '0;
      r_miss       <= '0;
      r_lost       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_tap        <= w_tap_nx;
      r_settle     <= w_settle_nx;
      r_chk        <= w_chk_nx;
      r_good       <= w_good_nx;
      r_slips      <= w_slips_nx;
      r_prev_frame <= frame_i;
      r_idelay_val <= w_idelay_val_nx;
      r_ld         <= w_ld_nx;
      r_bitslip    <= w_bitslip_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_error      <= w_error_nx;
      r_tap_sel    <= w_tap_sel_nx;
      r_eye_width  <= w_eye_width_nx;
`ifdef ADS5296A_ALIGN_MONITOR_EN
      r_err_cnt    <= w_err_cnt_nx;
      r_miss       <= w_miss_nx;
      r_lost       <= w_lost_nx;
`endif
    end
  end

  assign idelay_val_o = r_idelay_val;
  assign idelay_ld_o  = r_ld;
  assign bitslip_o    = r_bitslip;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign tap_o        = r_tap_sel;
  assign eye_width_o  = r_eye_width;
`ifdef ADS5296A_ALIGN_MONITOR_EN
  assign err_cnt_o    = r_err_cnt;
  assign lost_lock_o  = r_lost;
`endif

endmodule

// File: tb/tb_ads5296a_align_ctrl.sv
// Directed bench for ads5296a_align_ctrl with a behavioural PHY model
// (per-tap eye mask, bitslip-driven frame rotation).
module tb_ads5296a_align_ctrl;

  localparam logic [9:0] PAT = 10'h3E0;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic [9:0] frame_i;
  logic [4:0] idelay_val_o;
  logic       idelay_ld_o;
  logic       bitslip_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic [4:0] tap_o;
  logic [5:0] eye_width_o;
`ifdef ADS5296A_ALIGN_MONITOR_EN
  logic [15:0] err_cnt_o;
  logic        lost_lock_o;
`endif

  ads5296a_align_ctrl dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .frame_i      (frame_i),
    .idelay_val_o (idelay_val_o),
    .idelay_ld_o  (idelay_ld_o),
    .bitslip_o    (bitslip_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .tap_o        (tap_o),
    .eye_width_o  (eye_width_o)
`ifdef ADS5296A_ALIGN_MONITOR_EN
    ,
    .err_cnt_o    (err_cnt_o),
    .lost_lock_o  (lost_lock_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  // PHY model state and strobe bookkeeping
  logic [31:0] good_mask = '0;
  int          init_rot = 0;
  bit          slip_ok = 1'b1;
  bit          corrupt = 1'b0;
  int          cur_tap = 0;
  int          slips = 0;
  int          bad_ctr = 0;
  int          n_ld = 0;
  int          n_slip = 0;
  int          last_ld_val = -1;
  int          first_ld_val = -1;
  int          overlap = 0;
  int          min_gap = 1000;
  int          since = 1000;
  logic        busy_after_start, done_after_start, error_after_start;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] rotr(input logic [9:0] x, input int r);
    logic [19:0] d;
    d = {x, x};
    return d[r +: 10];
  endfunction

  // PHY: latch tap on ld, count slips, drive frame word on the falling edge.
  initial begin
    frame_i = PAT;
    forever begin
      @(negedge clk_i);
      since++;
      if (idelay_ld_o || bitslip_o) begin
        if (idelay_ld_o && bitslip_o) overlap++;
        if (since < min_gap) min_gap = since;
        since = 0;
      end
      if (idelay_ld_o) begin
        cur_tap = int'(idelay_val_o);
        if (n_ld == 0) first_ld_val = int'(idelay_val_o);
        last_ld_val = int'(idelay_val_o);
        n_ld++;
      end
      if (bitslip_o) begin
        slips++;
        n_slip++;
      end
      bad_ctr++;
      if (corrupt) frame_i = 10'h155;
      else if (good_mask[cur_tap]) frame_i = rotr(PAT, slip_ok ? (init_rot + slips) % 10 : 1);
      else frame_i = rotr(PAT, bad_ctr % 10);
    end
  end

  task automatic wait_end();
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < 5000 && !ended; i++) begin
      @(negedge clk_i);
      if (done_o || error_o) ended = 1'b1;
    end
    check("terminated", 32'(ended), 32'd1);
  endtask

  task automatic kick(input logic [31:0] mask, input int rot, input bit sok);
    good_mask = mask;
    init_rot  = rot;
    slip_ok   = sok;
    @(negedge clk_i);
    slips = 0; n_ld = 0; n_slip = 0; overlap = 0;
    min_gap = 1000; since = 1000; first_ld_val = -1; last_ld_val = -1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    busy_after_start  = busy_o;
    done_after_start  = done_o;
    error_after_start = error_o;
  endtask

  task automatic run_train(input logic [31:0] mask, input int rot, input bit sok);
    kick(mask, rot, sok);
    wait_end();
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_gap_ge9"}, 32'(min_gap >= 9), 32'd1);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_flags", {29'd0, done_o, error_o, idelay_ld_o}, 0);
    check("rst_vals", {16'd0, bitslip_o, idelay_val_o, tap_o, eye_width_o}, 0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Eye on taps 10..19, three slips needed
    run_train(32'h000F_FC00, 7, 1'b1);
    check("t1_busy_after_start", 32'(busy_after_start), 1);
    check("t1_done", {30'd0, done_o, error_o}, 32'b10);
    check("t1_tap", 32'(tap_o), 14);
    check("t1_eye", 32'(eye_width_o), 10);
    check("t1_n_ld", 32'(n_ld), 33);
    check("t1_first_ld", 32'(first_ld_val), 0);
    check("t1_last_ld", 32'(last_ld_val), 14);
    check("t1_slips", 32'(n_slip), 3);
    check("t1_busy_end", 32'(busy_o), 0);
    check_strobes("t1");

    // All taps good, already aligned
    run_train(32'hFFFF_FFFF, 0, 1'b1);
    check("t2_done_cleared", 32'(done_after_start), 0);
    check("t2_done", {30'd0, done_o, error_o}, 32'b10);
    check("t2_tap", 32'(tap_o), 15);
    check("t2_eye", 32'(eye_width_o), 32);
    check("t2_slips", 32'(n_slip), 0);
`ifdef ADS5296A_ALIGN_MONITOR_EN
    @(posedge clk_i); #1 corrupt = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 corrupt = 1'b0;
    @(negedge clk_i);
    check("mon_lost", 32'(lost_lock_o), 1);
    check("mon_err_cnt", 32'(err_cnt_o), 4);
    check("mon_done_clr", 32'(done_o), 0);
    repeat (5) @(negedge clk_i);
    check("mon_sticky", {15'd0, lost_lock_o, err_cnt_o}, {15'd0, 1'b1, 16'd4});
`endif

    // Two equal eyes: earlier wins
    run_train(32'h01F0_007C, 0, 1'b1);
    check("t3_done", {30'd0, done_o, error_o}, 32'b10);
    check("t3_tap", 32'(tap_o), 4);
    check("t3_eye", 32'(eye_width_o), 5);
`ifdef ADS5296A_ALIGN_MONITOR_EN
    check("t3_mon_cleared", {15'd0, lost_lock_o, err_cnt_o}, 0);
`endif

    // Eye too narrow
    run_train(32'h0000_0700, 0, 1'b1);
    check("t4_error", {30'd0, done_o, error_o}, 32'b01);
    check("t4_eye", 32'(eye_width_o), 3);
    check("t4_slips", 32'(n_slip), 0);
    check("t4_n_ld", 32'(n_ld), 32);

    // Frame never aligns: MAX_SLIPS pulses then FAIL
    run_train(32'hFFFF_FFFF, 0, 1'b0);
    check("t5_error", {30'd0, done_o, error_o}, 32'b01);
    check("t5_slips", 32'(n_slip), 10);
    check("t5_tap", 32'(tap_o), 15);
    check_strobes("t5");
    run_train(32'hFFFF_FFFF, 0, 1'b1);
    check("t5r_err_cleared", {31'd0, error_after_start}, 0);
    check("t5r_busy", 32'(busy_after_start), 1);
    check("t5r_first_ld", 32'(first_ld_val), 0);
    check("t5r_done", {30'd0, done_o, error_o}, 32'b10);

    // Async reset mid-sweep at tap 17
    kick(32'hFFFF_FFFF, 0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_i);
      if (idelay_ld_o && idelay_val_o == 5'd17) found = 1'b1;
    end
    check("t6_reached_17", 32'(found), 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_async_flags", {27'd0, busy_o, done_o, error_o, idelay_ld_o, bitslip_o}, 0);
    check("t6_async_vals", {16'd0, idelay_val_o, tap_o, eye_width_o}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_train(32'hFFFF_FFFF, 0, 1'b1);
    check("t6_first_ld", 32'(first_ld_val), 0);
    check("t6_n_ld", 32'(n_ld), 33);
    check("t6_done", {30'd0, done_o, error_o}, 32'b10);
    check("t6_tap", 32'(tap_o), 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
